fp_subtractor_seq: RTL

FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_round_pack.sv | 48 ++++
 rtl/fp_subtractor_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and constants for the sequential single-precision
//                subtractor: FSM state encoding, field widths and an unpack
//                struct with a significand helper (denormals flushed to zero).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int EXP_MAX = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        PACK   = 3'd4,
        DONE   = 3'd5
    } fpState_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fpFields_t;

    // Significand with hidden bit; an exponent of zero reads as zero.
    function automatic logic [FRAC_W:0] sigOf(input fpFields_t f);
        return (f.exp == '0) ? '0 : {1'b1, f.frac};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Final rounding and IEEE-754 single packing. Zero significand
//                or exponent <= 0 gives +0; exponent >= 255 saturates to inf.
//                Configuration macro: FP_SUB_RNE_EN (round-to-nearest-even;
//                when undefined the significand is truncated).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp,
    input  logic [FRAC_W:0]    sig,
    input  logic               guard,
    input  logic               round,
    input  logic               sticky,
    output logic [31:0]        word
);

    logic              w_roundUp;
    logic [FRAC_W+1:0] w_rounded;
    logic signed [9:0] w_expAdj;
    logic [FRAC_W-1:0] w_frac;

    // Round, absorb mantissa overflow into the exponent, then range-check.
    always_comb begin
`ifdef FP_SUB_RNE_EN
        w_roundUp = guard & (round | sticky | sig[0]);
`else
        // Round toward zero: the guard/round/sticky bits are dropped.
        w_roundUp = 1'b0 & (guard | round | sticky);
`endif
        w_rounded = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, w_roundUp};
        w_expAdj  = exp + (w_rounded[FRAC_W+1] ? 10'sd1 : 10'sd0);
        w_frac    = w_rounded[FRAC_W+1] ? w_rounded[FRAC_W:1] : w_rounded[FRAC_W-1:0];
        if (sig == '0 || exp <= 10'sd0) begin
            word = 32'd0;
        end else if (w_expAdj >= 10'(EXP_MAX)) begin
            word = {sign, 8'hFF, 23'd0};
        end else begin
            word = {sign, w_expAdj[EXP_W-1:0], w_frac};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_subtractor_seq
//  Description : Multi-cycle IEEE-754 single-precision A - B. Alignment and
//                left normalisation shift one bit per cycle; valid/ready on
//                both sides. Configuration macro: FP_SUB_RNE_EN (selects
//                round-to-nearest-even in fp_round_pack, else truncation).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_subtractor_seq
    import fp_pkg::*;
#(
    parameter int ALIGN_CAP = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out,
    output logic        busy
);

    localparam int CNT_W = (ALIGN_CAP < 1) ? 1 : $clog2(ALIGN_CAP + 1);

    fpState_e           r_state, w_nextState;
    logic [FRAC_W:0]    r_sigBig, r_sigSmall;
    logic               r_guard, r_round, r_sticky, r_carry;
    logic               r_sign, r_effSub;
    logic signed [9:0]  r_exp;
    logic [CNT_W-1:0]   r_alignCnt;
    logic [31:0]        r_out;

    // Operand decode at accept time
    fpFields_t          w_fa, w_fb;
    logic [FRAC_W:0]    w_sigA, w_sigB, w_sigSmall;
    logic [30:0]        w_magA, w_magB;
    logic               w_aBig, w_collapse;
    logic [EXP_W-1:0]   w_expBig, w_expSmall, w_diff;
    logic [27:0]        w_opBig, w_opSmall, w_sum;
    logic [31:0]        w_packed;

    assign w_fa       = A;
    assign w_fb       = B;
    assign w_sigA     = sigOf(w_fa);
    assign w_sigB     = sigOf(w_fb);
    assign w_magA     = (w_fa.exp == '0) ? '0 : {w_fa.exp, w_fa.frac};
    assign w_magB     = (w_fb.exp == '0) ? '0 : {w_fb.exp, w_fb.frac};
    assign w_aBig     = (w_magA >= w_magB);
    assign w_expBig   = w_aBig ? w_fa.exp : w_fb.exp;
    assign w_expSmall = w_aBig ? w_fb.exp : w_fa.exp;
    assign w_sigSmall = w_aBig ? w_sigB : w_sigA;
    assign w_diff     = w_expBig - w_expSmall;
    assign w_collapse = ({24'd0, w_diff} > 32'(ALIGN_CAP));

    // Magnitude datapath: {carry, significand, G, R, S}; larger minus smaller never underflows.
    assign w_opBig   = {1'b0, r_sigBig, 3'b000};
    assign w_opSmall = {1'b0, r_sigSmall, r_guard, r_round, r_sticky};
    assign w_sum     = r_effSub ? (w_opBig - w_opSmall) : (w_opBig + w_opSmall);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign Out       = r_out;

    fp_round_pack u_roundPack (
        .sign   (r_sign),
        .exp    (r_exp),
        .sig    (r_sigBig),
        .guard  (r_guard),
        .round  (r_round),
        .sticky (r_sticky),
        .word   (w_packed)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state sequencing
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = ALIGN;
            ALIGN:   if (r_alignCnt == '0) w_nextState = ADDSUB;
            ADDSUB:  w_nextState = (w_sum == '0) ? PACK : NORM;
            NORM:    if (r_carry || r_sigBig[FRAC_W]) w_nextState = PACK;
            PACK:    w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: capture, align, add/sub, normalise, pack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sigBig   <= '0;
            r_sigSmall <= '0;
            r_guard    <= 1'b0;
            r_round    <= 1'b0;
            r_sticky   <= 1'b0;
            r_carry    <= 1'b0;
            r_sign     <= 1'b0;
            r_effSub   <= 1'b0;
            r_exp      <= '0;
            r_alignCnt <= '0;
            r_out      <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sigBig   <= w_aBig ? w_sigA : w_sigB;
                    r_sigSmall <= w_collapse ? '0 : w_sigSmall;
                    r_guard    <= 1'b0;
                    r_round    <= 1'b0;
                    r_sticky   <= w_collapse & (|w_sigSmall);
                    r_carry    <= 1'b0;
                    r_sign     <= w_aBig ? w_fa.sign : ~w_fb.sign;
                    r_effSub   <= (w_fa.sign == w_fb.sign);
                    r_exp      <= {2'b00, w_expBig};
                    r_alignCnt <= w_collapse ? CNT_W'(ALIGN_CAP) : CNT_W'(w_diff);
                end
                ALIGN: if (r_alignCnt != '0) begin
                    r_sigSmall <= {1'b0, r_sigSmall[FRAC_W:1]};
                    r_guard    <= r_sigSmall[0];
                    r_round    <= r_guard;
                    r_sticky   <= r_sticky | r_round;
                    r_alignCnt <= r_alignCnt - CNT_W'(1);
                end
                ADDSUB: begin
                    {r_carry, r_sigBig, r_guard, r_round, r_sticky} <= w_sum;
                end
                NORM: begin
                    if (r_carry) begin
                        {r_sigBig, r_guard, r_round} <= {r_carry, r_sigBig, r_guard};
                        r_sticky <= r_sticky | r_round;
                        r_carry  <= 1'b0;
                        r_exp    <= r_exp + 10'sd1;
                    end else if (!r_sigBig[FRAC_W]) begin
                        {r_sigBig, r_guard, r_round} <= {r_sigBig[FRAC_W-1:0], r_guard, r_round, r_sticky};
                        r_exp <= r_exp - 10'sd1;
                    end
                end
                PACK:    r_out <= w_packed;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
